// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module   : note_player
// Purpose  : Square-wave note sequencer. Plays one note per valid/ready
//            handshake for a set duration and toggles LED on each completion.
// Revision : 1.0  initial release
// ============================================================================
module note_player #(
  parameter int HP_W     = 20,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [HP_W-1:0]  note_half_period,
  input  logic [DUR_W-1:0] note_duration,
  input  logic             stop,
  output logic             busy,
  output logic             speaker,
  output logic             speaker2,
  output logic             LED
);

  localparam int              c_TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t           r_state;
  logic [HP_W-1:0]  r_hp;
  logic [HP_W-1:0]  r_hp_cnt;
  logic [DUR_W-1:0] r_dur;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [c_TW-1:0]  r_tick_cnt;
  logic             r_speaker;
  logic             r_led;
  logic             r_ready;
  logic             r_busy;

  logic w_tick_last;
  logic w_hp_last;
  logic w_done;

  assign w_tick_last = (r_tick_cnt == c_TICK_LAST);
  assign w_hp_last   = (r_hp_cnt == r_hp - HP_W'(1));
  // A zero duration finishes immediately; otherwise dur_cnt never passes dur-1.
  assign w_done      = (r_dur == '0) || (w_tick_last && (r_dur_cnt == r_dur - DUR_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hp       <= '0;
      r_hp_cnt   <= '0;
      r_dur      <= '0;
      r_dur_cnt  <= '0;
      r_tick_cnt <= '0;
      r_speaker  <= 1'b0;
      r_led      <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (note_valid && !stop) begin
            r_hp       <= note_half_period;
            r_dur      <= note_duration;
            r_hp_cnt   <= '0;
            r_tick_cnt <= '0;
            r_dur_cnt  <= '0;
            r_state    <= S_PLAY;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_PLAY: begin
          if (stop || w_done) begin
            r_state   <= S_IDLE;
            r_speaker <= 1'b0;
            r_hp_cnt  <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            if (!stop) r_led <= ~r_led;
          end else begin
            if (r_hp == '0) begin
              r_speaker <= 1'b0;
            end else if (w_hp_last) begin
              r_speaker <= ~r_speaker;
              r_hp_cnt  <= '0;
            end else begin
              r_hp_cnt  <= r_hp_cnt + HP_W'(1);
            end
            if (w_tick_last) begin
              r_tick_cnt <= '0;
              r_dur_cnt  <= r_dur_cnt + DUR_W'(1);
            end else begin
              r_tick_cnt <= r_tick_cnt + c_TW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign note_ready = r_ready;
  assign busy       = r_busy;
  assign speaker    = r_speaker;
  assign speaker2   = r_speaker;
  assign LED        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_player
// Purpose  : Scoreboard bench for note_player (main instance TICK_DIV=4, plus
//            a narrow-width instance for extreme field values).
// Revision : 1.0  initial release
// ============================================================================
module tb_note_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        a_rst, a_valid, a_ready, a_stop, a_busy, a_spk, a_spk2, a_led;
  logic [19:0] a_hp;
  logic [15:0] a_dur;

  note_player #(.HP_W(20), .DUR_W(16), .TICK_DIV(4)) u_dut_a (
    .clk(clk), .reset(a_rst), .note_valid(a_valid), .note_ready(a_ready),
    .note_half_period(a_hp), .note_duration(a_dur), .stop(a_stop),
    .busy(a_busy), .speaker(a_spk), .speaker2(a_spk2), .LED(a_led)
  );

  // Narrow instance
  logic       b_rst, b_valid, b_ready, b_stop, b_busy, b_spk, b_spk2, b_led;
  logic [3:0] b_hp;
  logic [2:0] b_dur;

  note_player #(.HP_W(4), .DUR_W(3), .TICK_DIV(2)) u_dut_b (
    .clk(clk), .reset(b_rst), .note_valid(b_valid), .note_ready(b_ready),
    .note_half_period(b_hp), .note_duration(b_dur), .stop(b_stop),
    .busy(b_busy), .speaker(b_spk), .speaker2(b_spk2), .LED(b_led)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  typedef struct {
    int hp;
    int len;
    bit led;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_led = 1'b0;

  // Drive one note at a negedge, push its expectation at acceptance.
  task automatic send(input int hp, input int dur, input int len, input bit toggles, input int gap);
    exp_t e;
    int   n;
    a_hp    = 20'(hp);
    a_dur   = 16'(dur);
    a_valid = 1'b1;
    n = 0;
    while (!a_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", (n < 400) ? 1 : 0, 1);
    exp_led = exp_led ^ toggles;
    e.hp = hp; e.len = len; e.led = exp_led; e.gap = gap;
    exp_q.push_back(e);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (a_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", (n < 400) ? 1 : 0, 1);
  endtask

  // Monitor: one PLAY interval per expectation, speaker checked against model.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_busy = 1'b0;
  int   j = 0, mism = 0, idle_cnt = 0;

  always @(negedge clk) begin
    int es;
    if (a_rst) begin
      prev_busy = 1'b0;
      idle_cnt  = 0;
    end else begin
      if (a_busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", exp_q.size(), 1);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
        end
        j = 0;
        mism = 0;
      end
      if (a_busy) begin
        if (have_cur) begin
          es = (cur.hp == 0) ? 0 : ((j / cur.hp) % 2);
          if (a_spk !== es[0] || a_spk2 !== es[0]) mism++;
        end
        j++;
      end
      if (!a_busy && prev_busy && have_cur) begin
        check("play_len", j, cur.len);
        check("wave_mism", mism, 0);
        check("led_after", a_led, cur.led);
        check("ready_after", a_ready, 1);
        check("spk_idle", a_spk, 0);
        have_cur = 1'b0;
        idle_cnt = 0;
      end
      if (!a_busy) idle_cnt++;
      prev_busy = a_busy;
    end
  end

  initial begin
    int n, len, edges;
    bit bled;
    a_rst = 1'b1; a_valid = 1'b1; a_stop = 1'b0; a_hp = 20'd3; a_dur = 16'd5;
    b_rst = 1'b1; b_valid = 1'b0; b_stop = 1'b0; b_hp = 4'd0;  b_dur = 3'd0;

    // Reset held with note_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", a_busy, 0);
      check("rst_ready", a_ready, 1);
    end
    a_rst = 1'b0; a_valid = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", a_ready, 1);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_spk", a_spk, 0);
    check("post_rst_led", a_led, 0);

    // Basic tone
    send(3, 5, 20, 1'b1, -1);
    wait_idle_a();

    // Rest, then zero duration back-to-back
    send(0, 2, 8, 1'b1, -1);
    send(0, 0, 1, 1'b1, 1);
    wait_idle_a();

    // Abort: stop sampled at the 7th edge of PLAY
    repeat (2) @(negedge clk);
    send(2, 10, 7, 1'b0, -1);
    repeat (6) @(negedge clk);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_spk", a_spk, 0);

    // stop + valid together in IDLE: nothing accepted
    @(negedge clk);
    a_stop = 1'b1; a_valid = 1'b1; a_hp = 20'd2; a_dur = 16'd3;
    repeat (3) begin
      @(negedge clk);
      check("stop_wins_busy", a_busy, 0);
      check("stop_wins_ready", a_ready, 1);
    end
    a_stop = 1'b0; a_valid = 1'b0;
    @(negedge clk);

    // Back-to-back queue of three notes (first one at hp=1)
    send(1, 2, 8, 1'b1, -1);
    send(4, 1, 4, 1'b1, 1);
    send(2, 3, 12, 1'b1, 1);
    wait_idle_a();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_led", a_led, exp_led);

    // Extremes on narrow instance: hp=15, dur=7, TICK_DIV=2 -> 14 cycles
    bled = 1'b0;
    repeat (2) begin
      n = 0;
      while (!b_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      b_hp = 4'd15; b_dur = 3'd7; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      len = 0; edges = 0;
      while (b_busy && len < 100) begin
        if (b_spk !== 1'b0 || b_spk2 !== 1'b0) edges++;
        @(negedge clk);
        len++;
      end
      bled = ~bled;
      check("b_play_len", len, 14);
      check("b_spk_high", edges, 0);
      check("b_led", b_led, bled);
      check("b_ready", b_ready, 1);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
